// File: rtl/class_query_fsm.sv
// Streams the query HV and every binary class HV segment by segment, accumulates the Hamming distance per class and reports the argmin class.
// Latency: pred_valid_o rises NUM_CLASSES*NUM_SEGS+1 edges after the accepting edge.
// Backpressure: the result is held in S_RESULT until pred_ready_i; start_query is ignored outside S_IDLE.
module class_query_fsm #(
  parameter  int NUM_CLASSES = 5,
  parameter  int NUM_SEGS    = 20,
  parameter  int SEG_W       = 512,
  localparam int CLS_W       = $clog2(NUM_CLASSES),
  localparam int SEG_IW      = $clog2(NUM_SEGS),
  localparam int DIST_W      = $clog2(SEG_W*NUM_SEGS+1)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic              start_query,
  input  logic              class_hvs_ready,
  input  logic [SEG_W-1:0]  query_seg_i,
  input  logic [SEG_W-1:0]  class_seg_i,
  output logic              rd_en_o,
  output logic [CLS_W-1:0]  class_idx_o,
  output logic [SEG_IW-1:0] seg_idx_o,
  output logic              busy_o,
  output logic              err_not_ready_o,
  output logic              pred_valid_o,
  input  logic              pred_ready_i,
  output logic [CLS_W-1:0]  pred_class_o,
  output logic [DIST_W-1:0] pred_dist_o
);

  localparam int PC_W = $clog2(SEG_W+1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_RESULT} state_t;
  state_t state;

  // read pipeline: address/strobe delayed to line up with the memory data
  logic              d_vld;
  logic [CLS_W-1:0]  d_cls;
  logic [SEG_IW-1:0] d_seg;
  logic [DIST_W-1:0] acc;
  logic [DIST_W-1:0] best_dist;
  logic [CLS_W-1:0]  best_cls;

  logic [SEG_W-1:0]  diff;
  logic [PC_W-1:0]   pc;
  logic [DIST_W-1:0] sum;
  logic              take;
  logic [CLS_W-1:0]  nb_cls;
  logic [DIST_W-1:0] nb_dist;

  // per-segment popcount, running class sum and the argmin candidate for this cycle
  always_comb begin
    diff = query_seg_i ^ class_seg_i;
    pc   = '0;
    for (int i = 0; i < SEG_W; i++) begin
      pc = pc + PC_W'(diff[i]);
    end
    sum     = ((d_seg == '0) ? '0 : acc) + DIST_W'(pc);
    // strict less-than keeps the lower class index on ties
    take    = d_vld && (d_seg == SEG_IW'(NUM_SEGS-1)) && ((d_cls == '0) || (sum < best_dist));
    nb_cls  = take ? d_cls : best_cls;
    nb_dist = take ? sum   : best_dist;
  end

  // pipeline registers, distance accumulator and best-so-far tracking
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      d_vld     <= 1'b0;
      d_cls     <= '0;
      d_seg     <= '0;
      acc       <= '0;
      best_dist <= '0;
      best_cls  <= '0;
    end else begin
      d_vld <= rd_en_o;
      d_cls <= class_idx_o;
      d_seg <= seg_idx_o;
      if (d_vld) begin
        acc <= sum;
      end
      if (take) begin
        best_dist <= sum;
        best_cls  <= d_cls;
      end
    end
  end

  // control FSM with registered outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state           <= S_IDLE;
      rd_en_o         <= 1'b0;
      class_idx_o     <= '0;
      seg_idx_o       <= '0;
      busy_o          <= 1'b0;
      err_not_ready_o <= 1'b0;
      pred_valid_o    <= 1'b0;
      pred_class_o    <= '0;
      pred_dist_o     <= '0;
    end else begin
      err_not_ready_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (en && start_query) begin
            if (class_hvs_ready) begin
              state       <= S_READ;
              rd_en_o     <= 1'b1;
              busy_o      <= 1'b1;
              class_idx_o <= '0;
              seg_idx_o   <= '0;
            end else begin
              err_not_ready_o <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (seg_idx_o == SEG_IW'(NUM_SEGS-1)) begin
            seg_idx_o <= '0;
            if (class_idx_o == CLS_W'(NUM_CLASSES-1)) begin
              class_idx_o <= '0;
              rd_en_o     <= 1'b0;
              state       <= S_DRAIN;
            end else begin
              class_idx_o <= class_idx_o + 1'b1;
            end
          end else begin
            seg_idx_o <= seg_idx_o + 1'b1;
          end
        end
        S_DRAIN: begin
          // last segment's sum is folded in this cycle, so capture the combinational winner
          pred_class_o <= nb_cls;
          pred_dist_o  <= nb_dist;
          pred_valid_o <= 1'b1;
          state        <= S_RESULT;
        end
        S_RESULT: begin
          if (pred_ready_i) begin
            pred_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_class_query_fsm.sv
// Directed bench for class_query_fsm with SEG_W=8, NUM_SEGS=4, NUM_CLASSES=5.
// A registered segment-memory model answers reads one cycle after rd_en_o.
// Expected classes and distances are hand-computed from the loaded patterns.
module tb_class_query_fsm;
  localparam int NC = 5;
  localparam int NS = 4;
  localparam int SW = 8;

  logic       clk = 1'b0;
  logic       nrst;
  logic       en;
  logic       start_query;
  logic       class_hvs_ready;
  logic [7:0] query_seg_i;
  logic [7:0] class_seg_i;
  logic       rd_en_o;
  logic [2:0] class_idx_o;
  logic [1:0] seg_idx_o;
  logic       busy_o;
  logic       err_not_ready_o;
  logic       pred_valid_o;
  logic       pred_ready_i;
  logic [2:0] pred_class_o;
  logic [5:0] pred_dist_o;

  logic [7:0] qmem [NS];
  logic [7:0] cmem [NC][NS];

  int n_tests = 0;
  int n_fail  = 0;

  class_query_fsm #(.NUM_CLASSES(NC), .NUM_SEGS(NS), .SEG_W(SW)) dut (
    .clk(clk), .nrst(nrst), .en(en), .start_query(start_query),
    .class_hvs_ready(class_hvs_ready), .query_seg_i(query_seg_i),
    .class_seg_i(class_seg_i), .rd_en_o(rd_en_o), .class_idx_o(class_idx_o),
    .seg_idx_o(seg_idx_o), .busy_o(busy_o), .err_not_ready_o(err_not_ready_o),
    .pred_valid_o(pred_valid_o), .pred_ready_i(pred_ready_i),
    .pred_class_o(pred_class_o), .pred_dist_o(pred_dist_o)
  );

  always #5 clk = ~clk;

  // segment memories: data valid one cycle after the read strobe
  always @(posedge clk) begin
    if (rd_en_o) begin
      query_seg_i <= qmem[seg_idx_o];
      class_seg_i <= cmem[class_idx_o][seg_idx_o];
    end
  end

  task automatic clear_mem();
    for (int s = 0; s < NS; s++) begin
      qmem[s] = 8'h00;
      for (int c = 0; c < NC; c++) cmem[c][s] = 8'h00;
    end
  endtask

  // issues one query and follows it to pred_valid_o, checking the address stream
  task automatic run_query(input bit glitch, output int lat, output int rd_cnt,
                           output int seq_err, output bit timeout);
    int cyc;
    cyc = 0; rd_cnt = 0; seq_err = 0; timeout = 1'b0;
    @(negedge clk);
    start_query = 1'b1;
    @(posedge clk);
    #1 start_query = 1'b0;
    while (1) begin
      @(negedge clk);
      if (rd_en_o) begin
        if (seg_idx_o !== 2'(rd_cnt % NS) || class_idx_o !== 3'(rd_cnt / NS)) seq_err++;
        rd_cnt++;
      end
      if (glitch && rd_cnt == 6) begin
        en = 1'b0;
        class_hvs_ready = 1'b0;
      end
      if (pred_valid_o) break;
      if (cyc >= 60) begin
        timeout = 1'b1;
        break;
      end
      @(posedge clk);
      cyc++;
    end
    lat = cyc;
    en = 1'b1;
    class_hvs_ready = 1'b1;
  endtask

  task automatic do_accept();
    @(negedge clk);
    pred_ready_i = 1'b1;
    @(posedge clk);
    #1 pred_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++;
    if ({rd_en_o, busy_o, err_not_ready_o, pred_valid_o} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 0000", {rd_en_o, busy_o, err_not_ready_o, pred_valid_o});
    end
    n_tests++;
    if ({class_idx_o, seg_idx_o, pred_class_o, pred_dist_o} !== 14'b0) begin
      n_fail++;
      $display("FAIL reset_data: got %h required 0", {class_idx_o, seg_idx_o, pred_class_o, pred_dist_o});
    end
  endtask

  task automatic load_match();
    clear_mem();
    qmem[0] = 8'hA5; qmem[1] = 8'h3C; qmem[2] = 8'h0F; qmem[3] = 8'hF0;
    for (int c = 0; c < NC; c++)
      for (int s = 0; s < NS; s++)
        cmem[c][s] = qmem[s];
    // non-matching classes differ in segment 0 only: distances 1,1,2,-,2
    cmem[0][0] = qmem[0] ^ 8'h01;
    cmem[1][0] = qmem[0] ^ 8'h02;
    cmem[2][0] = qmem[0] ^ 8'h03;
    cmem[4][0] = qmem[0] ^ 8'h05;
  endtask

  task automatic test_match();
    int lat, rc, se; bit to;
    load_match();
    run_query(1'b0, lat, rc, se, to);
    n_tests++;
    if (to || pred_class_o !== 3'd3 || pred_dist_o !== 6'd0) begin
      n_fail++;
      $display("FAIL match: got class %0d dist %0d timeout %0d required class 3 dist 0", pred_class_o, pred_dist_o, to);
    end
    do_accept();
  endtask

  task automatic test_latency();
    int lat, rc, se; bit to;
    clear_mem();
    for (int c = 0; c < NC; c++)
      for (int s = 0; s <= c; s++)
        cmem[c][s] = 8'hFF;
    run_query(1'b0, lat, rc, se, to);
    n_tests++;
    if (rc != 20) begin
      n_fail++;
      $display("FAIL rd_en_count: got %0d required 20", rc);
    end
    n_tests++;
    if (se != 0) begin
      n_fail++;
      $display("FAIL addr_seq: got %0d errors required 0", se);
    end
    n_tests++;
    if (to || lat != 21) begin
      n_fail++;
      $display("FAIL latency: got %0d required 21", lat);
    end
    n_tests++;
    if (pred_class_o !== 3'd0 || pred_dist_o !== 6'd8) begin
      n_fail++;
      $display("FAIL staircase: got class %0d dist %0d required class 0 dist 8", pred_class_o, pred_dist_o);
    end
    do_accept();
  endtask

  task automatic test_tie_backpressure();
    int lat, rc, se, unstable; bit to;
    clear_mem();
    cmem[0][0] = 8'h7F;
    cmem[1][0] = 8'h1F;
    cmem[2][0] = 8'h3F;
    cmem[3][0] = 8'hFF;
    cmem[4][0] = 8'h07;
    cmem[4][2] = 8'h03;
    // en and class_hvs_ready drop mid-query; the query must still complete
    run_query(1'b1, lat, rc, se, to);
    n_tests++;
    if (to || pred_class_o !== 3'd1 || pred_dist_o !== 6'd5) begin
      n_fail++;
      $display("FAIL tie: got class %0d dist %0d timeout %0d required class 1 dist 5", pred_class_o, pred_dist_o, to);
    end
    unstable = 0;
    start_query = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pred_valid_o !== 1'b1 || pred_class_o !== 3'd1 || pred_dist_o !== 6'd5 || rd_en_o !== 1'b0) unstable++;
    end
    start_query = 1'b0;
    n_tests++;
    if (unstable != 0) begin
      n_fail++;
      $display("FAIL hold: got %0d unstable cycles required 0", unstable);
    end
    do_accept();
    n_tests++;
    if (pred_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL release: got valid %b busy %b required 0 0", pred_valid_o, busy_o);
    end
    unstable = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rd_en_o !== 1'b0 || busy_o !== 1'b0) unstable++;
    end
    n_tests++;
    if (unstable != 0) begin
      n_fail++;
      $display("FAIL idle_after: got %0d active cycles required 0", unstable);
    end
  endtask

  task automatic test_not_ready();
    @(negedge clk);
    class_hvs_ready = 1'b0;
    start_query = 1'b1;
    @(posedge clk);
    #1 start_query = 1'b0;
    n_tests++;
    if (err_not_ready_o !== 1'b1 || rd_en_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL err_pulse: got err %b rd_en %b busy %b required 1 0 0", err_not_ready_o, rd_en_o, busy_o);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (err_not_ready_o !== 1'b0 || rd_en_o !== 1'b0) begin
      n_fail++;
      $display("FAIL err_width: got err %b rd_en %b required 0 0", err_not_ready_o, rd_en_o);
    end
    class_hvs_ready = 1'b1;
    @(negedge clk);
    en = 1'b0;
    start_query = 1'b1;
    @(posedge clk);
    #1 start_query = 1'b0;
    en = 1'b1;
    @(negedge clk);
    n_tests++;
    if (rd_en_o !== 1'b0 || busy_o !== 1'b0 || err_not_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL en_gate: got rd_en %b busy %b err %b required 0 0 0", rd_en_o, busy_o, err_not_ready_o);
    end
  endtask

  task automatic test_reset_mid();
    int lat, rc, se; bit to;
    load_match();
    @(negedge clk);
    start_query = 1'b1;
    @(posedge clk);
    #1 start_query = 1'b0;
    repeat (7) @(negedge clk);
    n_tests++;
    if (rd_en_o !== 1'b1 || class_idx_o !== 3'd1 || seg_idx_o !== 2'd2) begin
      n_fail++;
      $display("FAIL mid_addr: got rd_en %b cls %0d seg %0d required 1 1 2", rd_en_o, class_idx_o, seg_idx_o);
    end
    nrst = 1'b0;
    #1;
    n_tests++;
    if ({rd_en_o, busy_o, err_not_ready_o, pred_valid_o, class_idx_o, seg_idx_o, pred_class_o, pred_dist_o} !== 18'b0) begin
      n_fail++;
      $display("FAIL async_reset: got %h required 0",
               {rd_en_o, busy_o, err_not_ready_o, pred_valid_o, class_idx_o, seg_idx_o, pred_class_o, pred_dist_o});
    end
    @(negedge clk);
    nrst = 1'b1;
    run_query(1'b0, lat, rc, se, to);
    n_tests++;
    if (to || rc != 20 || pred_class_o !== 3'd3 || pred_dist_o !== 6'd0) begin
      n_fail++;
      $display("FAIL after_reset: got class %0d dist %0d reads %0d required class 3 dist 0 reads 20", pred_class_o, pred_dist_o, rc);
    end
    do_accept();
  endtask

  initial begin
    nrst = 1'b0;
    en = 1'b1;
    start_query = 1'b0;
    class_hvs_ready = 1'b1;
    pred_ready_i = 1'b0;
    clear_mem();
    #3;
    test_reset();
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    test_match();
    test_latency();
    test_tie_backpressure();
    test_not_ready();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
